pdm_mic_capture: RTL
====================

// Module: pdm_mic_capture
// PURPOSE
//   Audio input path: the capture counterpart of the PWM audio output. Drives the
//   PDM microphone clock, samples the 1-bit PDM stream and decimates it to
//   unsigned 11-bit PCM samples. Samples use the same scale as the PWM generator
//   input, so captured audio can be looped back or sent to the bus peripheral.
//   Samples leave through a valid/ready handshake with a 1-entry holding register.
// PARAMETERS
//   CLK_DIV     10  CLK50MHZ cycles per M_CLK half-period (>=2); 10 -> 2.5 MHz M_CLK
//   DECIM       64  PDM bits per PCM sample (>=2); 64 -> 39.0625 kHz sample rate
//   SHIFT       4   left shift applied to the ones-count before saturation
//   OUT_W       11  PCM sample width (matches PWM input width)
//   SETTLE_WIN  2   windows discarded after EN rises (mic start-up)
// PORTS
//   CLK50MHZ      in   1      system clock, 50 MHz, single clock domain
//   RST_N         in   1      synchronous reset, active low
//   EN            in   1      capture enable
//   M_DATA        in   1      PDM data from microphone (asynchronous)
//   M_CLK         out  1      microphone clock
//   M_LRSEL       out  1      channel select, tied 0
//   SAMPLE        out  OUT_W  PCM sample, unsigned
//   SAMPLE_VALID  out  1      SAMPLE holds an unconsumed sample
//   SAMPLE_READY  in   1      consumer accepts SAMPLE this cycle when VALID=1
//   OVERRUN       out  1      sticky: a completed sample was dropped
//   CLR_OVR       in   1      clears OVERRUN (set has priority if same cycle)
// BEHAVIOUR
//   Reset (RST_N=0 at posedge): M_CLK=0, SAMPLE=0, SAMPLE_VALID=0, OVERRUN=0;
//     all counters, accumulator and sync flops =0; FSM=IDLE. Reset wins over all inputs.
//   FSM: IDLE -(EN=1)-> SETTLE -(SETTLE_WIN windows done)-> RUN; EN=0 from any state -> IDLE
//     next cycle. SETTLE_WIN=0 goes straight to RUN.
//   IDLE: M_CLK held 0; divider, bit counter, accumulator and settle counter cleared.
//     SAMPLE/SAMPLE_VALID kept, so a pending sample can still be consumed.
//   Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0 and M_CLK toggles.
//   M_DATA passes through a 2-flop synchronizer.
//   Bit strobe: the cycle with div_cnt==CLK_DIV-1 and M_CLK==1 (just before the falling
//     edge). On the strobe the synced bit is taken. One bit per 2*CLK_DIV cycles.
//   Window: bit_cnt counts 0..DECIM-1. ones accumulates, width $clog2(DECIM+1).
//     On the strobe with bit_cnt==DECIM-1, result = ones + bit. ones restarts at 0 and
//     bit_cnt wraps to 0. No bit is lost between windows.
//   Scaling: pcm = result << SHIFT; saturate to 2^OUT_W-1 if it exceeds that.
//   SETTLE: each window end increments settle_cnt; the result is discarded.
//   RUN window end (load cycle):
//     VALID=0, or VALID=1 and READY=1 -> SAMPLE<=pcm, VALID<=1 next cycle.
//     VALID=1 and READY=0 -> pcm dropped, SAMPLE unchanged, OVERRUN<=1.
//   Non-load cycle with VALID=1 and READY=1 -> VALID<=0 next cycle.
//   SAMPLE is stable while VALID=1 and READY=0.
//   Latency: window end to VALID = 1 cycle. Pipeline fill (M_DATA to bit taken) is 2 cycles.
//   Enabling EN mid-stream always restarts at div_cnt=0, M_CLK=0, settle_cnt=0.
// STRUCTURE
//   audio_pkg: CLK_HZ=50_000_000, AUDIO_W=11 (shared with pwm_module),
//     FSM state encodings IDLE/SETTLE/RUN.
//   Sub-module pdm_clkgen: divider, M_CLK and bit strobe, with synchronous clear on
//     ~EN. Window, FSM and handshake logic stay in the top module.
// TESTING (CLK_DIV=10, DECIM=64, SHIFT=4; bit period 20 cycles, window 1280 cycles)
//   1. RST_N=0 then 1, EN=1 -> all outputs 0 after reset; M_CLK period 20 cycles, duty 50%.
//   2. M_DATA=1 constant, READY=1 -> first VALID after 3 windows (~3840 cycles); SAMPLE=1024.
//   3. M_DATA=0 -> SAMPLE=0. M_DATA toggling each bit strobe -> SAMPLE=512. Never VALID in SETTLE.
//   4. SHIFT=5, M_DATA=1 -> SAMPLE=2047 (saturated). READY=0 over 2 RUN windows ->
//      first sample held, OVERRUN=1 after 2nd window end. CLR_OVR -> OVERRUN=0.
//   5. EN=0 mid-window -> M_CLK=0 next cycle, no VALID. Re-enable -> 2 windows discarded again.
//   6. RST_N=0 mid-window with VALID=1 -> next cycle VALID=0, SAMPLE=0, M_CLK=0, OVERRUN=0.

Source files
------------

// File: rtl/pdm_mic_capture_pkg.sv
// Shared audio constants and capture FSM state type.
// AUDIO_W is the sample width shared with the PWM generator.
package pdm_mic_capture_pkg;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned MCLK_HZ = 2_500_000;
    localparam int unsigned AUDIO_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/pdm_mic_capture_if.sv
// PCM sample handshake between the capture block (master) and its consumer (slave).
interface pdm_mic_capture_if
    import pdm_mic_capture_pkg::*;
#(
    parameter int unsigned OUT_W = AUDIO_W
) ();

    logic [OUT_W-1:0] SAMPLE;
    logic             SAMPLE_VALID;
    logic             SAMPLE_READY;
    logic             OVERRUN;
    logic             CLR_OVR;

    modport master (
        output SAMPLE, SAMPLE_VALID, OVERRUN,
        input  SAMPLE_READY, CLR_OVR
    );

    modport slave (
        input  SAMPLE, SAMPLE_VALID, OVERRUN,
        output SAMPLE_READY, CLR_OVR
    );

endinterface

// File: rtl/pdm_mic_capture_clkgen.sv
// Microphone clock divider; bit_stb marks the last system cycle before M_CLK falls.
module pdm_mic_capture_clkgen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic m_clk,
    output logic bit_stb
);

    localparam int unsigned    DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          m_clk_q, m_clk_d;
    logic          wrap;

    assign wrap = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        m_clk_d   = m_clk_q;
        if (clr) begin
            div_cnt_d = '0;
            m_clk_d   = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            m_clk_d   = ~m_clk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            m_clk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            m_clk_q   <= m_clk_d;
        end
    end

    assign m_clk   = m_clk_q;
    assign bit_stb = wrap && m_clk_q;

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone capture: drives M_CLK, counts ones per DECIM-bit window and
// emits saturated unsigned PCM samples through a 1-entry valid/ready register.
module pdm_mic_capture
    import pdm_mic_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_HZ / (2 * MCLK_HZ),
    parameter int unsigned DECIM      = 64,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned OUT_W      = AUDIO_W,
    parameter int unsigned SETTLE_WIN = 2
) (
    input  logic              CLK50MHZ,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              M_DATA,
    output logic              M_CLK,
    output logic              M_LRSEL,
    pdm_mic_capture_if.master cap
);

    localparam int unsigned BW = $clog2(DECIM);
    localparam int unsigned OW = $clog2(DECIM + 1);
    localparam int unsigned SW = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
    localparam int unsigned PW = OW + SHIFT;
    localparam int unsigned XW = (PW > OUT_W) ? PW : OUT_W;

    localparam logic [BW-1:0] BIT_LAST    = BW'(DECIM - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_WIN - 1);
    localparam logic [XW-1:0] SAT_MAX     = XW'((64'd1 << OUT_W) - 64'd1);

    cap_state_e       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [OUT_W-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             clkgen_clr;
    logic             bit_stb;
    logic             active;
    logic             win_end;
    logic             load;
    logic             ovr_set;
    logic [OW-1:0]    result;
    logic [XW-1:0]    scaled;
    logic [OUT_W-1:0] pcm;

    assign clkgen_clr = ~EN;

    pdm_mic_capture_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (CLK50MHZ),
        .rst_n   (RST_N),
        .clr     (clkgen_clr),
        .m_clk   (M_CLK),
        .bit_stb (bit_stb)
    );

    // The window-closing bit is folded into result so no bit is lost at the wrap.
    assign active  = EN && (state_q != ST_IDLE);
    assign win_end = active && bit_stb && (bit_cnt_q == BIT_LAST);
    assign result  = ones_q + OW'(sync2_q);
    assign scaled  = XW'(result) << SHIFT;
    assign pcm     = (scaled > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(scaled);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        load      = 1'b0;
        sync1_d   = M_DATA;
        sync2_d   = sync1_q;
        if (!EN) begin
            state_d   = ST_IDLE;
            settle_d  = '0;
            bit_cnt_d = '0;
            ones_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = (SETTLE_WIN == 0) ? ST_RUN : ST_SETTLE;
                    settle_d  = '0;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end
                ST_SETTLE: begin
                    if (win_end) begin
                        if (settle_q == SETTLE_LAST) begin
                            state_d  = ST_RUN;
                            settle_d = '0;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                end
                ST_RUN:  load = win_end;
                default: state_d = ST_IDLE;
            endcase
            if (active && bit_stb) begin
                if (win_end) begin
                    bit_cnt_d = '0;
                    ones_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    ones_d    = result;
                end
            end
        end
    end

    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        ovr_set  = 1'b0;
        if (load) begin
            if (!valid_q || cap.SAMPLE_READY) begin
                sample_d = pcm;
                valid_d  = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && cap.SAMPLE_READY) begin
            valid_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (cap.CLR_OVR) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign M_LRSEL          = 1'b0;
    assign cap.SAMPLE       = sample_q;
    assign cap.SAMPLE_VALID = valid_q;
    assign cap.OVERRUN      = ovr_q;

endmodule
